// File: rtl/core_ingress_arbiter.sv
// Two-slot ingress arbiter that shares one Core frame engine between the J and T links.
// Each slot holds one frame, and frames are granted round-robin, one in flight at a time.
module core_ingress_arbiter #(
   parameter int FRAME_SIZE     = 599,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GAP_CYCLES     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FRAME_SIZE:0] in_j_frame,
   input  logic                in_j_valid,
   output logic                in_j_ready,
   input  logic [FRAME_SIZE:0] in_t_frame,
   input  logic                in_t_valid,
   output logic                in_t_ready,
   output logic [FRAME_SIZE:0] core_fin_j,
   output logic                core_fin_j_valid,
   output logic [FRAME_SIZE:0] core_fin_t,
   output logic                core_fin_t_valid,
   input  logic                core_conf_jawny,
   input  logic                core_conf_tajny,
   input  logic [7:0]          core_conf_code,
   output logic                done_j,
   output logic                done_t,
   output logic [7:0]          done_code,
   output logic                fatal,
   output logic                busy
);

   localparam int MAXC = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(MAXC) + 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
   localparam logic [7:0] CODE_TIMEOUT = 8'hFF;
   localparam logic [7:0] CODE_FATAL   = 8'h08;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_CONF, S_DRAIN, S_GAP} state_t;

   state_t              state_q, state_d;
   logic [FRAME_SIZE:0] j_data_q, j_data_d, t_data_q, t_data_d;
   logic                j_full_q, j_full_d, t_full_q, t_full_d;
   logic                grant_q, grant_d;        // 0 = J, 1 = T
   logic                last_grant_q, last_grant_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [7:0]          code_q, code_d;
   logic                release_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         j_data_q     <= '0;
         t_data_q     <= '0;
         j_full_q     <= 1'b0;
         t_full_q     <= 1'b0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         timer_q      <= '0;
         code_q       <= '0;
      end else begin
         state_q      <= state_d;
         j_data_q     <= j_data_d;
         t_data_q     <= t_data_d;
         j_full_q     <= j_full_d;
         t_full_q     <= t_full_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         code_q       <= code_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      j_data_d     = j_data_q;
      t_data_d     = t_data_q;
      j_full_d     = j_full_q;
      t_full_d     = t_full_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      code_d       = code_q;
      release_w    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (j_full_q || t_full_q) begin
               if (j_full_q && t_full_q) grant_d = ~last_grant_q;
               else                      grant_d = t_full_q;
               last_grant_d = grant_d;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT_CONF;
         end
         S_WAIT_CONF: begin
            if (core_conf_jawny || core_conf_tajny) begin
               code_d  = core_conf_code;
               timer_d = '0;
               state_d = S_DRAIN;
            end else if (timer_q == TO_LAST) begin
               code_d  = CODE_TIMEOUT;
               timer_d = '0;
               state_d = S_DRAIN;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if ((!core_conf_jawny && !core_conf_tajny) || timer_q == TO_LAST) begin
               release_w = 1'b1;
               timer_d   = '0;
               state_d   = S_GAP;
               if (grant_q) t_full_d = 1'b0;
               else         j_full_d = 1'b0;
               // A fatal code flushes the peer slot too and restarts arbitration with J first.
               if (code_q == CODE_FATAL) begin
                  j_full_d     = 1'b0;
                  t_full_d     = 1'b0;
                  last_grant_d = 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_GAP: begin
            if (timer_q == GAP_LAST) begin
               timer_d = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Capture only into an empty slot, so it wins over a flush in the same cycle.
      if (in_j_valid && !j_full_q) begin
         j_data_d = in_j_frame;
         j_full_d = 1'b1;
      end
      if (in_t_valid && !t_full_q) begin
         t_data_d = in_t_frame;
         t_full_d = 1'b1;
      end
   end

   assign in_j_ready       = ~j_full_q;
   assign in_t_ready       = ~t_full_q;
   assign core_fin_j       = j_data_q;
   assign core_fin_t       = t_data_q;
   assign core_fin_j_valid = (state_q == S_ISSUE) && !grant_q;
   assign core_fin_t_valid = (state_q == S_ISSUE) &&  grant_q;
   assign done_j           = release_w && !grant_q;
   assign done_t           = release_w &&  grant_q;
   assign done_code        = release_w ? code_q : 8'h00;
   assign fatal            = release_w && (code_q == CODE_FATAL);
   assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_core_ingress_arbiter.sv
// Scoreboard bench for core_ingress_arbiter: expected issues and completions are queued
// when frames are offered and matched against the Core-side and done outputs.
module tb_core_ingress_arbiter;

   localparam int FS  = 599;
   localparam int FW  = FS + 1;
   localparam int TO  = 16;
   localparam int GAP = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [FS:0]   in_j_frame = '0, in_t_frame = '0;
   logic          in_j_valid = 1'b0, in_t_valid = 1'b0;
   logic          in_j_ready, in_t_ready;
   logic [FS:0]   core_fin_j, core_fin_t;
   logic          core_fin_j_valid, core_fin_t_valid;
   logic          core_conf_jawny = 1'b0, core_conf_tajny = 1'b0;
   logic [7:0]    core_conf_code = '0;
   logic          done_j, done_t, fatal, busy;
   logic [7:0]    done_code;

   core_ingress_arbiter #(.FRAME_SIZE(FS), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst),
      .in_j_frame(in_j_frame), .in_j_valid(in_j_valid), .in_j_ready(in_j_ready),
      .in_t_frame(in_t_frame), .in_t_valid(in_t_valid), .in_t_ready(in_t_ready),
      .core_fin_j(core_fin_j), .core_fin_j_valid(core_fin_j_valid),
      .core_fin_t(core_fin_t), .core_fin_t_valid(core_fin_t_valid),
      .core_conf_jawny(core_conf_jawny), .core_conf_tajny(core_conf_tajny),
      .core_conf_code(core_conf_code),
      .done_j(done_j), .done_t(done_t), .done_code(done_code), .fatal(fatal), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        side;   // 0 = J, 1 = T
      logic [FS:0] frame;
      logic [7:0]  code;
   } exp_t;

   exp_t iss_q[$];
   exp_t done_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_done = 0;
   bit   have_done = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [FS:0] mk_frame();
      logic [FS:0] f = '0;
      for (int i = 0; i < 19; i++) f = (f << 32) | FW'($urandom());
      return f;
   endfunction

   function automatic exp_t mk_exp(input logic side, input logic [FS:0] fr, input logic [7:0] code);
      exp_t e;
      e.side = side; e.frame = fr; e.code = code;
      return e;
   endfunction

   // Monitor: every Core issue and every done pulse is matched against the queues.
   always @(negedge clk) begin
      cyc++;
      if (core_fin_j_valid && core_fin_t_valid) begin
         chk("both_valid", 1, 0);
      end else if (core_fin_j_valid || core_fin_t_valid) begin
         if (iss_q.size() == 0) begin
            chk("unexpected_issue", 1, 0);
         end else begin
            mon_e = iss_q.pop_front();
            chk("issue_side", core_fin_t_valid, mon_e.side);
            chk("issue_frame", (core_fin_t_valid ? core_fin_t : core_fin_j) == mon_e.frame, 1);
            if (have_done) chk("issue_gap", (cyc - last_done) >= GAP + 1, 1);
         end
      end
      if (done_j && done_t) begin
         chk("both_done", 1, 0);
      end else if (done_j || done_t) begin
         last_done = cyc;
         have_done = 1;
         if (done_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_e = done_q.pop_front();
            chk("done_side", done_t, mon_e.side);
            chk("done_code", done_code, mon_e.code);
            chk("done_fatal", fatal, mon_e.code == 8'h08);
         end
      end else if (fatal) begin
         chk("stray_fatal", 1, 0);
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_ready(input bit need_j, input bit need_t);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!((!need_j || in_j_ready) && (!need_t || in_t_ready)) && n < 100);
      if (n >= 100) chk("ready_timeout", 0, 1);
   endtask

   task automatic drive(input bit dj, input logic [FS:0] fj, input bit dt, input logic [FS:0] ft);
      wait_ready(dj, dt);
      @(posedge clk); #1;
      if (dj) begin in_j_frame = fj; in_j_valid = 1'b1; end
      if (dt) begin in_t_frame = ft; in_t_valid = 1'b1; end
      @(posedge clk); #1;
      in_j_valid = 1'b0;
      in_t_valid = 1'b0;
   endtask

   task automatic wait_issue(output logic side, output int n);
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(core_fin_j_valid || core_fin_t_valid) && n < 200);
      if (n >= 200) chk("issue_timeout", 0, 1);
      side = core_fin_t_valid;
   endtask

   task automatic finish(input logic side, input int dly, input logic [7:0] code, input bit confirm);
      int n = 0;
      if (confirm) begin
         repeat (dly) @(posedge clk);
         @(posedge clk); #1;
         core_conf_jawny = !side;
         core_conf_tajny = side;
         core_conf_code  = code;
         repeat (2) @(posedge clk);
         #1;
         core_conf_jawny = 1'b0;
         core_conf_tajny = 1'b0;
         core_conf_code  = 8'h00;
      end
      do begin @(negedge clk); n++; end
      while (!(done_j || done_t) && n < 100);
      if (n >= 100) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("ready_after_done", side ? in_t_ready : in_j_ready, 1);
   endtask

   initial begin
      logic [FS:0] fj, ft;
      logic        s;
      int          n;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_j_ready", in_j_ready, 1);
      chk("rst_t_ready", in_t_ready, 1);
      chk("rst_valids", {core_fin_j_valid, core_fin_t_valid}, 0);
      chk("rst_done", {done_j, done_t, fatal}, 0);
      chk("rst_done_code", done_code, 0);
      chk("rst_fin_j", core_fin_j == '0, 1);

      // Single J frame, confirm 0x05 after a short delay
      fj = mk_frame();
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      done_q.push_back(mk_exp(1'b0, fj, 8'h05));
      drive(1, fj, 0, '0);
      wait_issue(s, n);
      chk("latency_full_to_valid", n, 2);
      finish(s, 3, 8'h05, 1);

      // Simultaneous J and T after reset: J first, then T
      do_reset();
      fj = mk_frame(); ft = mk_frame();
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      iss_q.push_back(mk_exp(1'b1, ft, 8'h00));
      done_q.push_back(mk_exp(1'b0, fj, 8'h05));
      done_q.push_back(mk_exp(1'b1, ft, 8'h05));
      drive(1, fj, 1, ft);
      wait_issue(s, n); finish(s, 0, 8'h05, 1);
      wait_issue(s, n); finish(s, 1, 8'h05, 1);

      // T returns 0x04 while a J frame waits in its slot
      ft = mk_frame(); fj = mk_frame();
      iss_q.push_back(mk_exp(1'b1, ft, 8'h00));
      done_q.push_back(mk_exp(1'b1, ft, 8'h04));
      drive(0, '0, 1, ft);
      wait_issue(s, n);
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      done_q.push_back(mk_exp(1'b0, fj, 8'h05));
      drive(1, fj, 0, '0);
      finish(s, 0, 8'h04, 1);
      chk("j_slot_kept_ready", in_j_ready, 0);
      chk("j_slot_kept_data", core_fin_j == fj, 1);
      wait_issue(s, n); finish(s, 0, 8'h05, 1);

      // Timeout on J, then the next tie goes to T
      do_reset();
      fj = mk_frame();
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      done_q.push_back(mk_exp(1'b0, fj, 8'hFF));
      drive(1, fj, 0, '0);
      wait_issue(s, n);
      finish(s, 0, 8'h00, 0);
      fj = mk_frame(); ft = mk_frame();
      iss_q.push_back(mk_exp(1'b1, ft, 8'h00));
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      done_q.push_back(mk_exp(1'b1, ft, 8'h05));
      done_q.push_back(mk_exp(1'b0, fj, 8'h05));
      drive(1, fj, 1, ft);
      wait_issue(s, n); finish(s, 0, 8'h05, 1);
      wait_issue(s, n); finish(s, 0, 8'h05, 1);

      // Fatal with both slots full flushes the T frame too
      do_reset();
      fj = mk_frame(); ft = mk_frame();
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      done_q.push_back(mk_exp(1'b0, fj, 8'h08));
      drive(1, fj, 1, ft);
      wait_issue(s, n);
      finish(s, 0, 8'h08, 1);
      chk("fatal_t_ready", in_t_ready, 1);
      repeat (10) @(negedge clk);
      chk("fatal_idle", busy, 0);

      // Reset during WAIT_CONF, then a normal frame with an unlisted code
      fj = mk_frame();
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      drive(1, fj, 0, '0);
      wait_issue(s, n);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", {in_j_ready, in_t_ready}, 2'b11);
      chk("midrst_done", {done_j, done_t, fatal}, 0);
      fj = mk_frame();
      iss_q.push_back(mk_exp(1'b0, fj, 8'h00));
      done_q.push_back(mk_exp(1'b0, fj, 8'h3C));
      drive(1, fj, 0, '0);
      wait_issue(s, n);
      chk("midrst_latency", n, 2);
      finish(s, 2, 8'h3C, 1);

      repeat (8) @(negedge clk);
      chk("issue_queue_empty", iss_q.size(), 0);
      chk("done_queue_empty", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
